// File: rtl/smart_timer_if.sv
// rtl/smart_timer_if.sv - timer request/response handshake between controller and smart_timer
//
// Purpose: groups the t_* request and response signals into one bundle.
// Signals:
//   t_start   controller -> timer  load t_length and begin counting
//   t_length  controller -> timer  interval in time units (5 bits)
//   t_freeze  controller -> timer  hold count and prescaler while high
//   t_done    timer -> controller  one-cycle pulse on expiry
//   t_flicker timer -> controller  one-cycle pulse per decrement inside the flicker window
//   t_count   timer -> controller  remaining units (5 bits)
//   t_busy    timer -> controller  high while an interval is running or frozen
// Modports: master = controller side, slave = timer side.

interface smart_timer_if;
    logic       t_start;
    logic [4:0] t_length;
    logic       t_freeze;
    logic       t_done;
    logic       t_flicker;
    logic [4:0] t_count;
    logic       t_busy;

    modport master (
        output t_start, t_length, t_freeze,
        input  t_done, t_flicker, t_count, t_busy
    );

    modport slave (
        input  t_start, t_length, t_freeze,
        output t_done, t_flicker, t_count, t_busy
    );
endinterface

// File: rtl/smart_timer.sv
// rtl/smart_timer.sv - countdown timer answering the traffic-light controller's t_* requests
//
// Purpose: counts down t_length time units of TICK_DIV clocks each, reports
// expiry with t_done and pulses t_flicker on each decrement that lands inside
// the flicker window. Optional feature macro: SMART_TIMER_FLICKER_EN
// (undefined: t_flicker is tied to 0 and its comparison logic is absent).
// Parameters:
//   TICK_DIV        clock cycles per time unit (1..65535)
//   FLICKER_WINDOW  remaining-count threshold for t_flicker pulses
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   tif      smart_timer_if.slave (t_start/t_length/t_freeze in,
//            t_done/t_flicker/t_count/t_busy out)

module smart_timer #(
    parameter int unsigned TICK_DIV       = 50,
    parameter logic [4:0]  FLICKER_WINDOW = 5'd4
) (
    input  logic         clk,
    input  logic         reset_n,
    smart_timer_if.slave tif
);

    localparam int unsigned   PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_count;
    logic [4:0]    w_count_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_expire;
    logic          w_expire_nxt;
    logic          r_done;
    logic          r_busy;
    logic [4:0]    w_count_dec;
    logic          w_dec_en;

    assign w_count_dec = r_count - 5'd1;

    // A unit elapses on the last prescaler cycle of a non-frozen active
    // interval; a simultaneous start discards the interval instead.
    assign w_dec_en = (r_state != ST_IDLE) && !tif.t_start && !tif.t_freeze
                      && (r_presc == P_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= 5'd0;
            r_presc  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_presc  <= w_presc_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_presc_nxt  = r_presc;
        w_expire_nxt = 1'b0;
        if (tif.t_start) begin
            w_count_nxt  = tif.t_length;
            w_presc_nxt  = '0;
            w_state_nxt  = (tif.t_length == 5'd0) ? ST_IDLE : ST_RUN;
            w_expire_nxt = (tif.t_length == 5'd0);
        end else begin
            case (r_state)
                ST_RUN, ST_HOLD: begin
                    if (tif.t_freeze) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        // Leaving HOLD advances the prescaler on the same edge,
                        // so each frozen cycle costs exactly one cycle.
                        w_state_nxt = ST_RUN;
                        if (r_presc == P_LAST) begin
                            w_presc_nxt = '0;
                            w_count_nxt = w_count_dec;
                            if (r_count == 5'd1) begin
                                w_state_nxt  = ST_IDLE;
                                w_expire_nxt = 1'b1;
                            end
                        end else begin
                            w_presc_nxt = r_presc + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output stage: t_done and t_busy trail the internal state by one edge,
    // which yields the L*TICK_DIV+1 start-to-done latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= r_expire && !tif.t_start;
            r_busy <= (r_state != ST_IDLE);
        end
    end

    assign tif.t_done  = r_done;
    assign tif.t_busy  = r_busy;
    assign tif.t_count = r_count;

`ifdef SMART_TIMER_FLICKER_EN
    logic r_flick_evt;
    logic r_flicker;

    // Decrement to zero is excluded: expiry is reported by t_done alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flick_evt <= 1'b0;
            r_flicker   <= 1'b0;
        end else begin
            r_flick_evt <= w_dec_en && (w_count_dec != 5'd0)
                           && (w_count_dec <= FLICKER_WINDOW);
            r_flicker   <= r_flick_evt && !tif.t_start;
        end
    end

    assign tif.t_flicker = r_flicker;
`else
    assign tif.t_flicker = 1'b0;
`endif

endmodule

// File: tb/tb_smart_timer.sv
// tb/tb_smart_timer.sv - directed self-checking bench for smart_timer

module tb_smart_timer;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    smart_timer_if tif ();

    smart_timer #(
        .TICK_DIV       (2),
        .FLICKER_WINDOW (5'd2)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tif     (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_timer(input logic [4:0] len);
        tif.t_start  = 1'b1;
        tif.t_length = len;
        tick();
        tif.t_start  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        tif.t_start  = 1'b0;
        tif.t_length = 5'd0;
        tif.t_freeze = 1'b0;
        tick();
        tick();
        checks++;
        if ({tif.t_done, tif.t_flicker, tif.t_busy, tif.t_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_init: got done=%b flk=%b busy=%b cnt=%0d, want all 0",
                     tif.t_done, tif.t_flicker, tif.t_busy, tif.t_count);
        end
        reset_n = 1'b1;
        tick();
        // Mid-run asynchronous reset
        start_timer(5'd7);
        tick();
        checks++;
        if (tif.t_count !== 5'd7 || tif.t_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: got cnt=%0d busy=%b, want cnt=7 busy=1",
                     tif.t_count, tif.t_busy);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tif.t_done, tif.t_flicker, tif.t_busy, tif.t_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got done=%b flk=%b busy=%b cnt=%0d, want all 0",
                     tif.t_done, tif.t_flicker, tif.t_busy, tif.t_count);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (tif.t_busy !== 1'b0 || tif.t_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b cnt=%0d, want busy=0 cnt=0",
                     tif.t_busy, tif.t_count);
        end
    endtask

    // L=3, TICK_DIV=2: count 3,3,2,2,1,1,0 after edges 0..6; done after edge 7
    task automatic test_basic();
        logic [4:0] exp_cnt;
        start_timer(5'd3);
        checks++;
        if (tif.t_count !== 5'd3 || tif.t_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: got cnt=%0d busy=%b, want cnt=3 busy=0",
                     tif.t_count, tif.t_busy);
        end
        for (int n = 1; n <= 9; n++) begin
            tick();
            exp_cnt = (n >= 6) ? 5'd0 : 5'(3 - n / 2);
            checks++;
            if (tif.t_count !== exp_cnt) begin
                errors++;
                $display("FAIL basic_count[%0d]: got %0d, want %0d", n, tif.t_count, exp_cnt);
            end
            checks++;
            if (tif.t_done !== (n == 7)) begin
                errors++;
                $display("FAIL basic_done[%0d]: got %b, want %b", n, tif.t_done, (n == 7));
            end
            checks++;
            if (tif.t_busy !== (n <= 6)) begin
                errors++;
                $display("FAIL basic_busy[%0d]: got %b, want %b", n, tif.t_busy, (n <= 6));
            end
        end
    endtask

    // L=5, window 2: decrements to 2 and 1 at edges 6 and 8 -> flicker after 7 and 9
    task automatic test_flicker();
        logic exp_flk;
        start_timer(5'd5);
        for (int n = 1; n <= 13; n++) begin
            tick();
`ifdef SMART_TIMER_FLICKER_EN
            exp_flk = (n == 7) || (n == 9);
`else
            exp_flk = 1'b0;
`endif
            checks++;
            if (tif.t_flicker !== exp_flk) begin
                errors++;
                $display("FAIL flicker[%0d]: got %b, want %b", n, tif.t_flicker, exp_flk);
            end
            checks++;
            if (tif.t_done !== (n == 11)) begin
                errors++;
                $display("FAIL flicker_done[%0d]: got %b, want %b", n, tif.t_done, (n == 11));
            end
        end
    endtask

    // L=2, freeze sampled on edges 2..5 -> done after edge 9 instead of 5
    task automatic test_freeze();
        start_timer(5'd2);
        tick();
        tif.t_freeze = 1'b1;
        for (int n = 2; n <= 11; n++) begin
            tick();
            if (n == 5) tif.t_freeze = 1'b0;
            if (n >= 2 && n <= 5) begin
                checks++;
                if (tif.t_count !== 5'd2 || tif.t_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL freeze_hold[%0d]: got cnt=%0d busy=%b, want cnt=2 busy=1",
                             n, tif.t_count, tif.t_busy);
                end
            end
            checks++;
            if (tif.t_done !== (n == 9)) begin
                errors++;
                $display("FAIL freeze_done[%0d]: got %b, want %b", n, tif.t_done, (n == 9));
            end
        end
    endtask

    task automatic test_restart();
        logic [4:0] exp_cnt;
        // Zero length: done on the next cycle, never busy
        start_timer(5'd0);
        checks++;
        if (tif.t_done !== 1'b0 || tif.t_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_e0: got done=%b busy=%b, want 0 0", tif.t_done, tif.t_busy);
        end
        tick();
        checks++;
        if (tif.t_done !== 1'b1 || tif.t_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b, want 1 0", tif.t_done, tif.t_busy);
        end
        tick();
        checks++;
        if (tif.t_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: got done=%b, want 0", tif.t_done);
        end
        // Abort at count 1 with reload of 4
        start_timer(5'd3);
        for (int n = 1; n <= 4; n++) tick();
        checks++;
        if (tif.t_count !== 5'd1) begin
            errors++;
            $display("FAIL abort_pre: got cnt=%0d, want 1", tif.t_count);
        end
        start_timer(5'd4);
        checks++;
        if (tif.t_count !== 5'd4) begin
            errors++;
            $display("FAIL abort_reload: got cnt=%0d, want 4", tif.t_count);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp_cnt = (n >= 8) ? 5'd0 : 5'(4 - n / 2);
            checks++;
            if (tif.t_count !== exp_cnt) begin
                errors++;
                $display("FAIL abort_count[%0d]: got %0d, want %0d", n, tif.t_count, exp_cnt);
            end
            checks++;
            if (tif.t_done !== (n == 9)) begin
                errors++;
                $display("FAIL abort_done[%0d]: got %b, want %b", n, tif.t_done, (n == 9));
            end
        end
    endtask

    // L=1 restarted in the cycle done is high
    task automatic test_back_to_back();
        start_timer(5'd1);
        tick();
        tick();
        tick();
        checks++;
        if (tif.t_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got done=%b, want 1", tif.t_done);
        end
        start_timer(5'd1);
        checks++;
        if (tif.t_done !== 1'b0 || tif.t_count !== 5'd1) begin
            errors++;
            $display("FAIL b2b_reload: got done=%b cnt=%0d, want 0 1", tif.t_done, tif.t_count);
        end
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if (tif.t_done !== (n == 3)) begin
                errors++;
                $display("FAIL b2b_done[%0d]: got %b, want %b", n, tif.t_done, (n == 3));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        tick();
        test_flicker();
        tick();
        test_freeze();
        tick();
        test_restart();
        tick();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smart_timer.md
# smart_timer

Countdown timer that services the traffic-light controller's timer request interface. It accepts `t_start`/`t_length`/`t_freeze` from the controller and returns `t_done` when a programmed interval expires. It also returns `t_flicker` pulses during the tail of the interval, which drive the pedestrian flicker phase. It sits beside the controller FSM and is the responder end of the t_* handshake.

## Interface
- `TICK_DIV`, default 50: clock cycles per time unit. Range 1..65535. The prescaler width is `$clog2(TICK_DIV)`, minimum 1.
- `FLICKER_WINDOW`, default 5'd4: remaining-count threshold at or below which `t_flicker` pulses.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `t_start`  in  1  load `t_length` and begin counting. Level is sampled each cycle.
- `t_length`  in  5  interval in time units; sampled only when `t_start`=1.
- `t_freeze`  in  1  hold count and prescaler while high.
- `t_done`  out  1  one-cycle pulse on expiry.
- `t_flicker`  out  1  one-cycle pulse per unit decrement inside the flicker window.
- `t_count`  out  5  remaining units.
- `t_busy`  out  1  high in RUN or HOLD.

## Operation
- States:
  - IDLE (`t_count` is static).
  - RUN (counting).
  - HOLD (frozen).
- Reset (`reset_n`=0, any time, including mid-count):
  - state becomes IDLE; `t_count`=0 and prescaler=0;
  - `t_done`=0, `t_flicker`=0, `t_busy`=0.
- `t_start`=1 in any state is the highest priority:
  - `t_count` ← `t_length`; prescaler ← 0; state → RUN.
  - Any in-flight interval is discarded and no `t_done` is issued for it.
- Start with `t_length`=0: state → IDLE immediately, and `t_done` pulses on the next cycle.
- RUN with `t_freeze`=0:
  - The prescaler increments each cycle.
  - At `TICK_DIV`-1 the prescaler wraps to 0 and `t_count` decrements by 1.
- Decrement to 0: state → IDLE and `t_done`=1 for exactly one cycle.
- Decrement to a value v with 1 ≤ v ≤ `FLICKER_WINDOW`: `t_flicker`=1 for one cycle.
  - A decrement to 0 never produces `t_flicker`.
- RUN with `t_freeze`=1 → HOLD. Count and prescaler hold their values; no pulses are generated.
- HOLD with `t_freeze`=0 → RUN. The prescaler resumes from its held value.
- `t_freeze` in IDLE is ignored.
- `t_start` and `t_freeze` together: the start wins and the next state is RUN.
  - If `t_freeze` is still high on the following cycle, the block enters HOLD.
- `t_count` never underflows. `t_count` is 0 whenever the block is in IDLE after an expiry.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start-to-done latency for L ≥ 1 with no freeze: exactly L·`TICK_DIV`+1 cycles from the `t_start` edge to the cycle in which `t_done` is high.
- Each freeze cycle in RUN adds exactly 1 cycle of latency.
- `t_done` and `t_flicker` are single-cycle pulses and are never high together.
- Restart on expiry: the controller may assert `t_start` in the cycle `t_done` is high.
  - That cycle's reload takes effect at the next edge.
  - `t_done` deasserts on that edge.
- `t_busy` rises on the edge after `t_start` (when L ≥ 1) and falls on the edge where `t_done` rises.

## Configuration
- `SMART_TIMER_FLICKER_EN`
  - Defined: `t_flicker` behaves as described above.
  - Undefined: the flicker comparison logic is removed and `t_flicker` is tied to 0. All other behaviour and latency are unchanged.

## Test plan
- Reset values: `reset_n`=0 mid-RUN with `t_count`=7 → all outputs 0 and state IDLE, asynchronously (before the next `clk` edge).
- Basic interval: `TICK_DIV`=2, `t_start` with `t_length`=3 → `t_count` steps 3,2,1,0; `t_done` is high exactly 7 cycles after the start edge, for 1 cycle.
- Flicker pulses: `TICK_DIV`=2, `FLICKER_WINDOW`=2, `t_length`=5 → `t_flicker` pulses at counts 2 and 1 only; no pulse at 0; `t_done` follows.
- Freeze: `TICK_DIV`=2, `t_length`=2, `t_freeze` high for 4 cycles mid-count → `t_count` holds and `t_done` arrives at cycle 9 instead of 5.
- Restart and zero length:
  - `t_start` with `t_length`=0 → `t_done` on the next cycle.
  - `t_start` with `t_length`=4 during RUN at `t_count`=1 → reload to 4 with no `t_done` for the aborted interval.
- Macro off: build without `SMART_TIMER_FLICKER_EN`, rerun the flicker scenario → `t_flicker` stays 0 and `t_done` timing is identical.
